// File: rtl/trace_stim_sequencer_pkg.sv
// trace_stim_sequencer_pkg: shared FSM states, mode codes, LFSR taps and DUT input-bus bit map.
package trace_stim_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAND,
        S_DATA,
        S_SETTLE,
        S_SAMPLE,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_RANDOM = 2'd0;
    localparam logic [1:0] MODE_FIXED  = 2'd1;
    localparam logic [1:0] MODE_TVLA   = 2'd2;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int BIT_A  = 3;
    localparam int BIT_B  = 2;
    localparam int BIT_R1 = 1;
    localparam int BIT_R2 = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/trace_stim_sequencer_lfsr16.sv
// trace_stim_sequencer_lfsr16: seedable 16-bit Galois LFSR with advance enable.
// Exposes both the current value and the value it will take on the next advance.
module trace_stim_sequencer_lfsr16
    import trace_stim_sequencer_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] q,
    output logic [15:0] q_next
);

    assign q_next = lfsr_step(q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= SEED;
        else if (adv)
            q <= q_next;
    end

endmodule

// File: rtl/trace_stim_sequencer.sv
// trace_stim_sequencer: drives masked shares, then data, into a 2-gate DUT per trace,
// samples its output after a settle window and raises a scope trigger around evaluation.
module trace_stim_sequencer
    import trace_stim_sequencer_pkg::*;
#(
    parameter int          IN_SIZE       = 4,
    parameter int          OUT_SIZE      = 1,
    parameter int          CNT_W         = 16,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          mode,
    input  logic [1:0]          fixed_ab,
    input  logic [CNT_W-1:0]    n_traces,
    input  logic [OUT_SIZE-1:0] dut_out,
    output logic [IN_SIZE-1:0]  dut_in,
    output logic                trigger,
    output logic                busy,
    output logic                done,
    output logic                res_valid,
    output logic [OUT_SIZE-1:0] res_data,
    output logic                res_class,
    output logic [CNT_W-1:0]    trace_idx
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    state_t            state, nxt;
    logic [CNT_W-1:0]  n_lat, idx;
    logic [SW-1:0]     cnt;
    logic [15:0]       lfsr, lfsr_next;
    logic              cls;
    logic [1:0]        ab;
    logic              unused_lfsr;

    trace_stim_sequencer_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (state == S_RAND && nxt == S_DATA),
        .q      (lfsr),
        .q_next (lfsr_next)
    );

    assign unused_lfsr = ^{lfsr[15:5], lfsr_next[15:2]};

    always_comb begin
        cls = (mode == MODE_FIXED) || (mode == MODE_TVLA && lfsr[4]);
        ab  = cls ? fixed_ab : {lfsr[2], lfsr[3]};
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (start) nxt = (n_traces == '0) ? S_DONE : S_RAND;
            S_RAND:   nxt = S_DATA;
            S_DATA:   nxt = S_SETTLE;
            S_SETTLE: if (cnt == SW'(SETTLE_CYCLES - 1)) nxt = S_SAMPLE;
            S_SAMPLE: nxt = S_CLEAR;
            S_CLEAR:  nxt = (CNT_W'(idx + 1'b1) == n_lat) ? S_DONE : S_RAND;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        // Abort precharges the bus through CLEAR before finishing; from CLEAR itself go straight to DONE
        if (abort && state inside {S_RAND, S_DATA, S_SETTLE, S_SAMPLE, S_CLEAR})
            nxt = (state == S_CLEAR) ? S_DONE : S_CLEAR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            n_lat     <= '0;
            idx       <= '0;
            cnt       <= '0;
            dut_in    <= '0;
            res_data  <= '0;
            res_class <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= (state == S_SETTLE) ? cnt + 1'b1 : '0;
            if (state == S_IDLE && start) begin
                n_lat <= n_traces;
                idx   <= '0;
            end
            if (state == S_CLEAR && nxt == S_RAND)
                idx <= idx + 1'b1;
            // Shares land one cycle before data so the two never toggle together
            if (nxt == S_CLEAR) begin
                dut_in <= '0;
            end else if (state == S_RAND) begin
                dut_in[BIT_R1] <= lfsr_next[0];
                dut_in[BIT_R2] <= lfsr_next[1];
            end else if (state == S_DATA) begin
                dut_in[BIT_A] <= ab[1];
                dut_in[BIT_B] <= ab[0];
                res_class     <= cls;
            end
            if (nxt == S_SAMPLE)
                res_data <= dut_out;
        end
    end

    assign trigger   = (state == S_SETTLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign res_valid = (state == S_SAMPLE);
    assign trace_idx = idx;

endmodule

// File: tb/tb_trace_stim_sequencer.sv
// tb_trace_stim_sequencer: randomized campaigns checked against a trace-level model
// of the share/data/class sequence derived from the LFSR polynomial.
module tb_trace_stim_sequencer;

    localparam int          S    = 4;
    localparam int          P    = S + 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 0, rst_n = 0, start = 0, abort = 0;
    logic [1:0]  mode = 0, fixed_ab = 0;
    logic [15:0] n_traces = 0, trace_idx;
    logic        dut_out, trigger, busy, done, res_valid, res_data, res_class;
    logic [3:0]  dut_in;

    int          checks = 0, errors = 0;
    logic [15:0] m_lfsr = SEED;

    int          n_rv, n_trig, n_done, done_cyc, n_unstable, n_busy_bad;
    int          trig_rise[256], trig_len[256];
    logic [3:0]  trig_din[256], pre_din[256], fall_din[256], clr_din[256];
    logic        rv_data[256], rv_cls[256];
    logic [15:0] rv_idx[256];
    logic [3:0]  t0_pre, t0_trig;

    trace_stim_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .fixed_ab  (fixed_ab),
        .n_traces  (n_traces),
        .dut_out   (dut_out),
        .dut_in    (dut_in),
        .trigger   (trigger),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_class (res_class),
        .trace_idx (trace_idx)
    );

    // Stand-in for the masked gate: output depends on every input bit
    assign dut_out = ^dut_in;

    always #5 clk = ~clk;

    // One trace of the reference: advance LFSR, return {class, a, b, r1, r2}
    function automatic logic [4:0] model_trace(input logic [1:0] md, input logic [1:0] fab);
        logic c;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        c = (md == 2'd1) || (md == 2'd2 && m_lfsr[4]);
        return {c, c ? fab : {m_lfsr[2], m_lfsr[3]}, m_lfsr[0], m_lfsr[1]};
    endfunction

    task automatic do_reset();
        rst_n  = 0;
        start  = 0;
        abort  = 0;
        m_lfsr = SEED;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Runs one campaign and records what the outputs did, cycle by cycle
    task automatic run(input logic [1:0] md, input logic [1:0] fab, input logic [15:0] n,
                       input int abort_trace, input int restart_at);
        int run_len = 0, tail = 0;
        logic prev_trig = 0, prev_rv = 0;
        logic [3:0] prev_din = 0;
        n_rv = 0; n_trig = 0; n_done = 0; done_cyc = -1; n_unstable = 0; n_busy_bad = 0;
        for (int i = 0; i < 256; i++) begin
            trig_rise[i] = -1; trig_len[i] = -1;
            trig_din[i] = 'x; pre_din[i] = 'x; fall_din[i] = 'x; clr_din[i] = 'x;
            rv_data[i] = 'x; rv_cls[i] = 'x; rv_idx[i] = 'x;
        end
        @(negedge clk);
        mode = md; fixed_ab = fab; n_traces = n; start = 1;
        @(negedge clk);
        start = 0;
        n_traces = 16'($urandom);
        for (int cyc = 1; cyc < 3000 && tail < 4; cyc++) begin
            if (trigger) begin
                if (!prev_trig && n_trig < 256) begin
                    trig_rise[n_trig] = cyc;
                    trig_din[n_trig]  = dut_in;
                    pre_din[n_trig]   = prev_din;
                end
                if (prev_trig && dut_in !== prev_din) n_unstable++;
                run_len++;
            end else if (prev_trig && n_trig < 256) begin
                trig_len[n_trig] = run_len;
                fall_din[n_trig] = dut_in;
                n_trig++;
                run_len = 0;
            end
            if (prev_rv && n_rv > 0) clr_din[n_rv-1] = dut_in;
            if (res_valid && n_rv < 256) begin
                rv_data[n_rv] = res_data;
                rv_cls[n_rv]  = res_class;
                rv_idx[n_rv]  = trace_idx;
                n_rv++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                abort = 0;
            end
            if (busy !== (done_cyc < 0 || cyc == done_cyc)) n_busy_bad++;
            if (done_cyc >= 0) tail++;
            if (abort_trace >= 0 && trigger && n_trig == abort_trace && run_len == 2) abort = 1;
            start = (cyc == restart_at);
            prev_trig = trigger; prev_rv = res_valid; prev_din = dut_in;
            @(negedge clk);
        end
        start = 0;
        abort = 0;
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL timeout: done never seen (got none, want one pulse)");
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({dut_in, trigger, busy, done, res_valid, res_data, res_class, trace_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%b%b%b%b%b%b/%h want all zero",
                     dut_in, trigger, busy, done, res_valid, res_data, res_class, trace_idx);
        end
    endtask

    task automatic test_traces(input logic [1:0] md, input logic [1:0] fab, input int n,
                               input bit rst, input bit save);
        logic [4:0] e;
        if (rst) do_reset();
        run(md, fab, 16'(n), -1, -1);
        checks++; if (n_rv !== n)       begin errors++; $display("FAIL m%0d res_count got %0d want %0d", md, n_rv, n); end
        checks++; if (n_trig !== n)     begin errors++; $display("FAIL m%0d trig_count got %0d want %0d", md, n_trig, n); end
        checks++; if (n_done !== 1)     begin errors++; $display("FAIL m%0d done_count got %0d want 1", md, n_done); end
        checks++; if (done_cyc !== P*n+1) begin errors++; $display("FAIL m%0d done_cycle got %0d want %0d", md, done_cyc, P*n+1); end
        checks++; if (n_unstable !== 0) begin errors++; $display("FAIL m%0d din_unstable got %0d want 0", md, n_unstable); end
        checks++; if (n_busy_bad !== 0) begin errors++; $display("FAIL m%0d busy_bad got %0d want 0", md, n_busy_bad); end
        for (int k = 0; k < n; k++) begin
            e = model_trace(md, fab);
            checks++; if (pre_din[k] !== {2'b00, e[1:0]}) begin errors++; $display("FAIL m%0d t%0d shares got %b want %b", md, k, pre_din[k], {2'b00, e[1:0]}); end
            checks++; if (trig_din[k] !== e[3:0])  begin errors++; $display("FAIL m%0d t%0d din got %b want %b", md, k, trig_din[k], e[3:0]); end
            checks++; if (trig_len[k] !== S)       begin errors++; $display("FAIL m%0d t%0d trig_len got %0d want %0d", md, k, trig_len[k], S); end
            checks++; if (trig_rise[k] !== 3+P*k)  begin errors++; $display("FAIL m%0d t%0d trig_rise got %0d want %0d", md, k, trig_rise[k], 3+P*k); end
            checks++; if (rv_cls[k] !== e[4])      begin errors++; $display("FAIL m%0d t%0d class got %b want %b", md, k, rv_cls[k], e[4]); end
            checks++; if (rv_data[k] !== ^e[3:0])  begin errors++; $display("FAIL m%0d t%0d data got %b want %b", md, k, rv_data[k], ^e[3:0]); end
            checks++; if (rv_idx[k] !== 16'(k))    begin errors++; $display("FAIL m%0d t%0d idx got %0d want %0d", md, k, rv_idx[k], k); end
            checks++; if (clr_din[k] !== 4'b0)     begin errors++; $display("FAIL m%0d t%0d clear_din got %b want 0000", md, k, clr_din[k]); end
        end
        if (save) begin
            t0_pre  = pre_din[0];
            t0_trig = trig_din[0];
        end
    endtask

    task automatic test_zero_and_busy();
        logic [4:0] e;
        logic [1:0] fab;
        run(2'd1, 2'b01, 16'd0, -1, -1);
        checks++; if (n_trig !== 0)     begin errors++; $display("FAIL zero trig_count got %0d want 0", n_trig); end
        checks++; if (n_rv !== 0)       begin errors++; $display("FAIL zero res_count got %0d want 0", n_rv); end
        checks++; if (n_done !== 1)     begin errors++; $display("FAIL zero done_count got %0d want 1", n_done); end
        checks++; if (done_cyc !== 1)   begin errors++; $display("FAIL zero done_cycle got %0d want 1", done_cyc); end
        checks++; if (n_busy_bad !== 0) begin errors++; $display("FAIL zero busy_bad got %0d want 0", n_busy_bad); end
        fab = 2'($urandom);
        run(2'd2, fab, 16'd2, -1, 5);
        checks++; if (n_rv !== 2)       begin errors++; $display("FAIL busy_start res_count got %0d want 2", n_rv); end
        checks++; if (n_done !== 1)     begin errors++; $display("FAIL busy_start done_count got %0d want 1", n_done); end
        checks++; if (done_cyc !== 2*P+1) begin errors++; $display("FAIL busy_start done_cycle got %0d want %0d", done_cyc, 2*P+1); end
        for (int k = 0; k < 2; k++) begin
            e = model_trace(2'd2, fab);
            checks++; if (trig_din[k] !== e[3:0]) begin errors++; $display("FAIL busy_start t%0d din got %b want %b", k, trig_din[k], e[3:0]); end
        end
    endtask

    task automatic test_abort();
        logic [4:0] e;
        logic [1:0] fab;
        fab = 2'($urandom);
        run(2'd2, fab, 16'd5, 2, -1);
        checks++; if (n_rv !== 2)        begin errors++; $display("FAIL abort res_count got %0d want 2", n_rv); end
        checks++; if (n_trig !== 3)      begin errors++; $display("FAIL abort trig_count got %0d want 3", n_trig); end
        checks++; if (trig_len[2] !== 2) begin errors++; $display("FAIL abort trig_len got %0d want 2", trig_len[2]); end
        checks++; if (fall_din[2] !== 4'b0) begin errors++; $display("FAIL abort din got %b want 0000", fall_din[2]); end
        checks++; if (n_done !== 1)      begin errors++; $display("FAIL abort done_count got %0d want 1", n_done); end
        checks++; if (done_cyc !== trig_rise[2] + 3) begin errors++; $display("FAIL abort done_cycle got %0d want %0d", done_cyc, trig_rise[2] + 3); end
        for (int k = 0; k < 3; k++) begin
            e = model_trace(2'd2, fab);
            checks++; if (trig_din[k] !== e[3:0]) begin errors++; $display("FAIL abort t%0d din got %b want %b", k, trig_din[k], e[3:0]); end
            if (k < 2) begin
                checks++; if (rv_data[k] !== ^e[3:0]) begin errors++; $display("FAIL abort t%0d data got %b want %b", k, rv_data[k], ^e[3:0]); end
            end
        end
    endtask

    task automatic test_async_reset();
        int waited = 0;
        @(negedge clk);
        mode = 2'd0; n_traces = 16'd5; start = 1;
        @(negedge clk);
        start = 0;
        while (!trigger && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL async pre_trigger got %b want 1", trigger); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({dut_in, trigger, busy, done, res_valid, res_data, res_class, trace_idx} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs got %h/%b%b%b%b%b%b/%h want all zero",
                     dut_in, trigger, busy, done, res_valid, res_data, res_class, trace_idx);
        end
        @(negedge clk);
        rst_n  = 1;
        m_lfsr = SEED;
        run(2'd0, 2'b00, 16'd1, -1, -1);
        checks++; if (n_rv !== 1)           begin errors++; $display("FAIL async res_count got %0d want 1", n_rv); end
        checks++; if (pre_din[0] !== t0_pre)  begin errors++; $display("FAIL async shares got %b want %b", pre_din[0], t0_pre); end
        checks++; if (trig_din[0] !== t0_trig) begin errors++; $display("FAIL async din got %b want %b", trig_din[0], t0_trig); end
    endtask

    initial begin
        test_reset();
        test_traces(2'd1, 2'b10, 3, 1'b0, 1'b0);
        test_traces(2'd0, 2'($urandom), 5, 1'b1, 1'b1);
        test_traces(2'd2, 2'($urandom), 64, 1'b0, 1'b0);
        test_zero_and_busy();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
